event_stat_regfile: RTL and testbench

EVENT_STAT_REGFILE -- requirements
Module: event_stat_regfile

---
 rtl/event_stat_regfile.sv | 173 +++++++++++++++++
 tb/tb_event_stat_regfile.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/event_stat_regfile.sv
// Per-channel event counters with snapshot registers, overflow flags and a
// Wishbone register file (one wait state per access).
module event_stat_regfile #(
  parameter int NUM_CHAN = 4,
  parameter int CNT_W    = 32,
  parameter int RUNCFG_W = 12
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [12:0]         wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  input  logic [3:0]          wb_sel_i,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                wb_rty_o,
  output logic [31:0]         wb_dat_o,
  input  logic [NUM_CHAN-1:0] event_i,
  output logic                cnt_reset_o,
  output logic                snap_o,
  output logic [NUM_CHAN-1:0] mask_o,
  output logic [RUNCFG_W-1:0] runcfg_o
);

  localparam logic [4:0] REG_CTRL   = 5'd0;
  localparam logic [4:0] REG_RUNCFG = 5'd1;
  localparam logic [4:0] REG_OVF    = 5'd2;
  localparam logic [4:0] REG_MASK   = 5'd3;
  localparam int         REG_SNAP0  = 4;

  // Bus handshake: a request (cyc & stb) is acknowledged one cycle after it
  // first appears; read data is captured in that first cycle and a write
  // takes effect on the edge that ends the acknowledged cycle.
  logic                ack_q;
  logic [31:0]         dat_q, dat_d;
  logic                cnt_reset_q, cnt_reset_d;
  logic                sat_q, sat_d;
  logic                clr_q, clr_d;
  logic                snap_q, snap_d;
  logic [RUNCFG_W-1:0] runcfg_q, runcfg_d;
  logic [NUM_CHAN-1:0] mask_q, mask_d;
  logic [NUM_CHAN-1:0] ovf_q, ovf_d;
  logic [CNT_W-1:0]    cnt_q  [NUM_CHAN];
  logic [CNT_W-1:0]    cnt_d  [NUM_CHAN];
  logic [CNT_W-1:0]    snapv_q[NUM_CHAN];
  logic [CNT_W-1:0]    snapv_d[NUM_CHAN];

  logic [4:0]          reg_idx;
  logic [31:0]         wmask;
  logic                wr_en;
  logic                snap_take;
  logic [NUM_CHAN-1:0] inc;
  logic [NUM_CHAN-1:0] ovf_set;
  logic [NUM_CHAN-1:0] ovf_clr;
  logic [31:0]         rdata;
  logic                unused_ok;

  assign reg_idx   = wb_adr_i[6:2];
  assign wmask     = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign wb_ack_o  = ack_q & wb_cyc_i & wb_stb_i;
  assign wr_en     = wb_ack_o & wb_we_i;
  assign wb_err_o  = 1'b0;
  assign wb_rty_o  = 1'b0;
  assign wb_dat_o  = dat_q;
  assign snap_take = snap_q & ~cnt_reset_q;
  assign snap_o    = snap_take;
  assign cnt_reset_o = cnt_reset_q;
  assign mask_o    = mask_q;
  assign runcfg_o  = runcfg_q;
  assign unused_ok = ^{wb_adr_i[12:7], wb_adr_i[1:0], wb_dat_i, wmask};

  // Control, configuration and mask registers.
  always_comb begin
    cnt_reset_d = cnt_reset_q;
    sat_d       = sat_q;
    clr_d       = clr_q;
    snap_d      = 1'b0;
    runcfg_d    = runcfg_q;
    mask_d      = mask_q;
    ovf_clr     = '0;
    if (wr_en && reg_idx == REG_CTRL && wb_sel_i[0]) begin
      cnt_reset_d = wb_dat_i[0];
      snap_d      = wb_dat_i[1];
      sat_d       = wb_dat_i[2];
      clr_d       = wb_dat_i[3];
    end
    if (wr_en && reg_idx == REG_RUNCFG) begin
      runcfg_d = (runcfg_q & ~wmask[RUNCFG_W-1:0]) |
                 (wb_dat_i[RUNCFG_W-1:0] & wmask[RUNCFG_W-1:0]);
    end
    if (wr_en && reg_idx == REG_MASK) begin
      mask_d = (mask_q & ~wmask[NUM_CHAN-1:0]) |
               (wb_dat_i[NUM_CHAN-1:0] & wmask[NUM_CHAN-1:0]);
    end
    if (wr_en && reg_idx == REG_OVF) begin
      ovf_clr = wb_dat_i[NUM_CHAN-1:0] & wmask[NUM_CHAN-1:0];
    end
  end

  // Live counters; with clr_on_snap the snapshot cycle's own event seeds the
  // next window so nothing is dropped across the boundary.
  always_comb begin
    for (int k = 0; k < NUM_CHAN; k++) begin
      inc[k]     = event_i[k] & mask_q[k] & ~cnt_reset_q;
      ovf_set[k] = inc[k] & (&cnt_q[k]);
      cnt_d[k]   = cnt_q[k];
      snapv_d[k] = snapv_q[k];
      if (cnt_reset_q) begin
        cnt_d[k] = '0;
      end else if (snap_take && clr_q) begin
        cnt_d[k] = CNT_W'(inc[k]);
      end else if (inc[k]) begin
        if (&cnt_q[k]) cnt_d[k] = sat_q ? cnt_q[k] : '0;
        else           cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
      if (snap_take) snapv_d[k] = cnt_q[k];
    end
    // A same-cycle overflow beats the write-1-to-clear.
    ovf_d = (ovf_q & ~ovf_clr) | ovf_set;
  end

  always_comb begin
    rdata = '0;
    case (reg_idx)
      REG_CTRL:   rdata[3:0] = {clr_q, sat_q, 1'b0, cnt_reset_q};
      REG_RUNCFG: rdata[RUNCFG_W-1:0] = runcfg_q;
      REG_OVF:    rdata[NUM_CHAN-1:0] = ovf_q;
      REG_MASK:   rdata[NUM_CHAN-1:0] = mask_q;
      default: begin
        for (int k = 0; k < NUM_CHAN; k++) begin
          if (reg_idx == 5'(REG_SNAP0 + k)) rdata[CNT_W-1:0] = snapv_q[k];
        end
      end
    endcase
    dat_d = dat_q;
    if (wb_cyc_i && wb_stb_i && !wb_we_i && !wb_ack_o) dat_d = rdata;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q       <= 1'b0;
      dat_q       <= '0;
      cnt_reset_q <= 1'b0;
      sat_q       <= 1'b0;
      clr_q       <= 1'b0;
      snap_q      <= 1'b0;
      runcfg_q    <= '0;
      mask_q      <= '1;
      ovf_q       <= '0;
      for (int k = 0; k < NUM_CHAN; k++) begin
        cnt_q[k]   <= '0;
        snapv_q[k] <= '0;
      end
    end else begin
      ack_q       <= wb_cyc_i & wb_stb_i;
      dat_q       <= dat_d;
      cnt_reset_q <= cnt_reset_d;
      sat_q       <= sat_d;
      clr_q       <= clr_d;
      snap_q      <= snap_d;
      runcfg_q    <= runcfg_d;
      mask_q      <= mask_d;
      ovf_q       <= ovf_d;
      for (int k = 0; k < NUM_CHAN; k++) begin
        cnt_q[k]   <= cnt_d[k];
        snapv_q[k] <= snapv_d[k];
      end
    end
  end

endmodule

// File: tb/tb_event_stat_regfile.sv
// Directed bench for event_stat_regfile: register reads are scored against an
// expected queue filled when each read is issued.
module tb_event_stat_regfile;
  localparam int NUM_CHAN = 4;
  localparam int CNT_W    = 4;
  localparam int RUNCFG_W = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [12:0]         adr = '0;
  logic [31:0]         wdat = '0;
  logic [3:0]          sel = '0;
  logic                ack, err, rty;
  logic [31:0]         rdat;
  logic [NUM_CHAN-1:0] ev = '0;
  logic                cnt_reset, snap;
  logic [NUM_CHAN-1:0] mask;
  logic [RUNCFG_W-1:0] runcfg;

  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;

  event_stat_regfile #(.NUM_CHAN(NUM_CHAN), .CNT_W(CNT_W), .RUNCFG_W(RUNCFG_W)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_ack_o(ack), .wb_err_o(err),
    .wb_rty_o(rty), .wb_dat_o(rdat), .event_i(ev), .cnt_reset_o(cnt_reset),
    .snap_o(snap), .mask_o(mask), .runcfg_o(runcfg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic bus_cycle(input logic [4:0] r, input logic w, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd, output int waits,
                           output logic ok);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = {6'b0, r, 2'b00}; wdat = d; sel = s;
    waits = 0;
    @(negedge clk);
    while (!ack && waits < 8) begin
      waits++;
      @(negedge clk);
    end
    ok = ack;
    rd = rdat;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    int          waits;
    logic        ok;
    bus_cycle(r, 1'b1, d, s, rd, waits, ok);
    check("wr_ack", {31'b0, ok}, 32'd1);
  endtask

  task automatic rd_raw(input logic [4:0] r, output logic [31:0] rd);
    int   waits;
    logic ok;
    bus_cycle(r, 1'b0, '0, 4'hF, rd, waits, ok);
    check("rd_raw_ack", {31'b0, ok}, 32'd1);
  endtask

  // scoreboard: expectation queued at issue, popped when the ack returns data
  task automatic rd_check(input string tag, input logic [4:0] r, input logic [31:0] e);
    logic [31:0] rd, exp_v;
    int          waits;
    logic        ok;
    exp_q.push_back(e);
    bus_cycle(r, 1'b0, '0, 4'hF, rd, waits, ok);
    check({tag, "_ack"}, {31'b0, ok}, 32'd1);
    check({tag, "_wait"}, waits, 32'd1);
    exp_v = exp_q.pop_front();
    check(tag, rd, exp_v);
  endtask

  task automatic pulse(input logic [NUM_CHAN-1:0] m, input int n);
    @(posedge clk); #1 ev = m;
    repeat (n) @(posedge clk);
    #1 ev = '0;
  endtask

  task automatic check_snap_pulse(input string tag, input logic e1);
    @(negedge clk); check({tag, "_snap_hi"}, {31'b0, snap}, {31'b0, e1});
    @(negedge clk); check({tag, "_snap_lo"}, {31'b0, snap}, 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    int sum;
    // reset with a bus request left pending: it must never be acked
    cyc = 1'b1; stb = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_cnt_reset", {31'b0, cnt_reset}, 32'd0);
    check("rst_mask", {28'b0, mask}, 32'hF);
    check("rst_runcfg", {16'b0, runcfg}, 32'd0);
    check("rst_snap", {31'b0, snap}, 32'd0);
    check("err_rty", {30'b0, err, rty}, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ack", {31'b0, ack}, 32'd0);
    rd_check("rst_ctrl", 5'd0, 32'd0);
    rd_check("rst_mask_rd", 5'd3, 32'hF);
    rd_check("rst_ovf", 5'd2, 32'd0);
    rd_check("rst_snap0", 5'd4, 32'd0);
    rd_check("rst_runcfg_rd", 5'd1, 32'd0);

    // basic snapshot; live count keeps running afterwards
    pulse(4'b0001, 10);
    wr(5'd0, 32'h2, 4'hF);
    check_snap_pulse("snap1", 1'b1);
    rd_check("snap0_10", 5'd4, 32'd10);
    pulse(4'b0001, 5);
    wr(5'd0, 32'h2, 4'hF);
    rd_check("snap0_15", 5'd4, 32'd15);
    rd_check("ctrl_snap_reads0", 5'd0, 32'd0);
    rd_check("ovf_none", 5'd2, 32'd0);

    // wrap mode overflow on channel 1
    wr(5'd0, 32'h1, 4'hF);
    check("cnt_reset_o_hi", {31'b0, cnt_reset}, 32'd1);
    wr(5'd0, 32'h0, 4'hF);
    check("cnt_reset_o_lo", {31'b0, cnt_reset}, 32'd0);
    pulse(4'b0010, 17);
    wr(5'd0, 32'h2, 4'hF);
    rd_check("wrap_snap1", 5'd5, 32'd1);
    rd_check("wrap_ovf", 5'd2, 32'h2);
    rd_check("wrap_snap0_cleared", 5'd4, 32'd0);
    wr(5'd2, 32'h2, 4'hF);
    rd_check("ovf_w1c", 5'd2, 32'd0);

    // saturating mode on channel 2
    wr(5'd0, 32'h1, 4'hF);
    wr(5'd0, 32'h4, 4'hF);
    pulse(4'b0100, 20);
    wr(5'd0, 32'h6, 4'hF);
    rd_check("sat_snap2", 5'd6, 32'd15);
    rd_check("sat_ovf", 5'd2, 32'h4);
    rd_check("sat_snap1", 5'd5, 32'd0);
    rd_check("sat_ctrl", 5'd0, 32'h4);
    // overflow in the same cycle as its clear keeps the flag
    @(posedge clk); #1 ev = 4'b0100;
    wr(5'd2, 32'h4, 4'hF);
    @(posedge clk); #1 ev = '0;
    rd_check("ovf_set_wins", 5'd2, 32'h4);
    wr(5'd2, 32'h4, 4'hF);
    rd_check("ovf_cleared", 5'd2, 32'd0);

    // clear-on-snapshot with a continuous event stream
    wr(5'd0, 32'h1, 4'hF);
    wr(5'd0, 32'h8, 4'hF);
    sum = 0;
    fork
      pulse(4'b0100, 30);
      begin
        repeat (4) begin
          repeat (2) @(posedge clk);
          wr(5'd0, 32'hA, 4'hF);
          rd_raw(5'd6, v);
          sum += int'(v);
        end
      end
    join
    wr(5'd0, 32'hA, 4'hF);
    rd_raw(5'd6, v);
    sum += int'(v);
    check("clr_snap_sum", sum, 32'd30);

    // masking and counter reset
    wr(5'd0, 32'h1, 4'hF);
    wr(5'd0, 32'h0, 4'hF);
    wr(5'd3, 32'h1, 4'hF);
    check("mask_o_1", {28'b0, mask}, 32'h1);
    wr(5'd3, 32'hF, 4'h0);
    check("mask_sel0_ignored", {28'b0, mask}, 32'h1);
    pulse(4'b1001, 6);
    wr(5'd0, 32'h2, 4'hF);
    rd_check("masked_snap3", 5'd7, 32'd0);
    rd_check("unmasked_snap0", 5'd4, 32'd6);
    wr(5'd0, 32'h1, 4'hF);
    pulse(4'b0001, 3);
    wr(5'd0, 32'h3, 4'hF);
    check_snap_pulse("snap_in_reset", 1'b0);
    rd_check("no_snap_in_reset", 5'd4, 32'd6);
    wr(5'd0, 32'h2, 4'hF);
    rd_check("snap_after_reset", 5'd4, 32'd0);
    wr(5'd3, 32'hF, 4'hF);
    check("mask_o_restored", {28'b0, mask}, 32'hF);

    // byte lanes and unmapped offsets
    wr(5'd1, 32'h0000_0123, 4'hF);
    check("runcfg_full", {16'b0, runcfg}, 32'h0123);
    wr(5'd1, 32'h0000_AB00, 4'b0010);
    check("runcfg_lane1", {16'b0, runcfg}, 32'hAB23);
    wr(5'd1, 32'hFFFF_FFFF, 4'b0001);
    check("runcfg_lane0", {16'b0, runcfg}, 32'hABFF);
    rd_check("runcfg_rd", 5'd1, 32'hABFF);
    rd_check("off31", 5'd31, 32'd0);
    wr(5'd31, 32'hFFFF_FFFF, 4'hF);
    rd_check("off31_after_wr", 5'd31, 32'd0);
    rd_check("off8_unmapped", 5'd8, 32'd0);

    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
